// File: rtl/cpu_pkg.sv
// Opcode/condition-code constants and the ID->EX control bundle shared by the decode stage.
// No timing of its own; helper functions are purely combinational.
package cpu_pkg;

    localparam int NUM_REGS = 16;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [2:0] CC_NEQ = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GTE = 3'b100;
    localparam logic [2:0] CC_LTE = 3'b101;
    localparam logic [2:0] CC_OVF = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    typedef struct packed {
        logic       regwrite;
        logic       alusrc;
        logic       memenable;
        logic       memwrite;
        logic       memtoreg;
        logic       pcread;
        logic [3:0] aluop;
    } ex_ctrl_t;

    // flag bits are ordered {Z, V, N}
    function automatic logic cond_met(input logic [2:0] cc, input logic [2:0] zvn);
        logic z, v, n;
        {z, v, n} = zvn;
        case (cc)
            CC_NEQ:  cond_met = ~z;
            CC_EQ:   cond_met = z;
            CC_GT:   cond_met = ~z & ~n;
            CC_LT:   cond_met = n;
            CC_GTE:  cond_met = z | (~z & ~n);
            CC_LTE:  cond_met = n | z;
            CC_OVF:  cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

    function automatic logic sets_flags(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR};
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// 16-entry register file, 2 async read ports, 1 sync write port; R0 reads zero.
// Optional same-cycle write-through; write port never stalls.
module regfile_bypass
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        i_rd_addr1,
    input  logic [3:0]        i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    input  logic              i_wr_en,
    input  logic [3:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
        end else if (i_wr_en && i_wr_addr != 4'd0) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data1 = r_mem[i_rd_addr1];
        if (i_rd_addr1 == 4'd0)
            o_rd_data1 = '0;
        else if (BYPASS && i_wr_en && i_wr_addr == i_rd_addr1)
            o_rd_data1 = i_wr_data;

        o_rd_data2 = r_mem[i_rd_addr2];
        if (i_rd_addr2 == 4'd0)
            o_rd_data2 = '0;
        else if (BYPASS && i_wr_en && i_wr_addr == i_rd_addr2)
            o_rd_data2 = i_wr_data;
    end

endmodule

// File: rtl/id_pipe_stage.sv
// Decode stage: IF/ID + ID/EX registers, load-use/flag stalls, branch resolve, sticky HLT; one cycle IF/ID->ID/EX.
// in_ready drops on a stall, on halt, or while EX holds a valid entry with ex_ready low.
module id_pipe_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [2:0]        flag,
    input  logic              wb_we,
    input  logic [3:0]        wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              ex_valid,
    input  logic              ex_ready,
    output ex_ctrl_t          ex_ctrl,
    output logic [3:0]        ex_src1,
    output logic [3:0]        ex_src2,
    output logic [3:0]        ex_dst,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic              halted
);

    logic              r_ifid_vld;
    logic [15:0]       r_ifid_instr;
    logic [DATA_W-1:0] r_ifid_pc;

    logic [3:0]        w_op, w_src1, w_src2, w_dst;
    logic              w_is_imm8, w_is_shift, w_is_br, w_use1, w_use2;
    logic [DATA_W-1:0] w_imm, w_rf1, w_rf2, w_data1, w_data2, w_pc_next, w_boff;
    ex_ctrl_t          w_ctrl;
    logic              w_stall, w_ex_free, w_issue, w_ifid_adv, w_hlt_issue;

    assign w_op       = r_ifid_instr[15:12];
    assign w_is_imm8  = (w_op == OP_LLB) || (w_op == OP_LHB);
    assign w_is_shift = w_op inside {OP_SLL, OP_SRA, OP_ROR};
    assign w_is_br    = (w_op == OP_B) || (w_op == OP_BR);
    assign w_src1     = w_is_imm8 ? r_ifid_instr[11:8] : r_ifid_instr[7:4];
    assign w_src2     = (w_op == OP_SW) ? r_ifid_instr[11:8] : r_ifid_instr[3:0];
    assign w_dst      = r_ifid_instr[11:8];
    // Which source fields actually carry a register operand (for load-use detection)
    assign w_use1     = (w_op <= OP_SW) || w_is_imm8 || (w_op == OP_BR);
    assign w_use2     = ((w_op <= OP_PADDSB) && !w_is_shift) || (w_op == OP_SW);

    always_comb begin
        w_imm = '0;
        if (w_is_imm8)
            w_imm = {{(DATA_W-8){1'b0}}, r_ifid_instr[7:0]};
        else if (w_op == OP_LW || w_op == OP_SW || w_is_shift)
            w_imm = {{(DATA_W-4){r_ifid_instr[3]}}, r_ifid_instr[3:0]};
    end

    always_comb begin
        w_ctrl       = '0;
        w_ctrl.aluop = w_op;
        case (w_op)
            OP_LW:          begin w_ctrl.regwrite = 1'b1; w_ctrl.alusrc = 1'b1;
                                  w_ctrl.memenable = 1'b1; w_ctrl.memtoreg = 1'b1; end
            OP_SW:          begin w_ctrl.alusrc = 1'b1; w_ctrl.memenable = 1'b1;
                                  w_ctrl.memwrite = 1'b1; end
            OP_LLB, OP_LHB: begin w_ctrl.regwrite = 1'b1; w_ctrl.alusrc = 1'b1; end
            OP_PCS:         begin w_ctrl.regwrite = 1'b1; w_ctrl.pcread = 1'b1; end
            OP_B, OP_BR, OP_HLT: ;
            default:        begin w_ctrl.regwrite = 1'b1; w_ctrl.alusrc = w_is_shift; end
        endcase
    end

    regfile_bypass #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rf (
        .clk        (clk),
        .rst        (rst),
        .i_rd_addr1 (w_src1),
        .i_rd_addr2 (w_src2),
        .o_rd_data1 (w_rf1),
        .o_rd_data2 (w_rf2),
        .i_wr_en    (wb_we),
        .i_wr_addr  (wb_dst),
        .i_wr_data  (wb_data)
    );

    assign w_pc_next = r_ifid_pc + DATA_W'(2);
    assign w_data1   = (w_op == OP_PCS) ? w_pc_next : w_rf1;
    assign w_data2   = (w_op == OP_PCS) ? '0 : w_rf2;
    assign w_boff    = {{(DATA_W-10){r_ifid_instr[8]}}, r_ifid_instr[8:0], 1'b0};

    // ex_ctrl.memtoreg is only ever set by LW; aluop carries the opcode for flag tracking
    assign w_stall = r_ifid_vld && ex_valid &&
                     ((ex_ctrl.memtoreg && ((w_use1 && ex_dst == w_src1) ||
                                            (w_use2 && ex_dst == w_src2))) ||
                      (w_is_br && sets_flags(ex_ctrl.aluop)));

    assign w_ex_free   = !ex_valid || ex_ready;
    assign w_issue     = r_ifid_vld && !w_stall && w_ex_free;
    assign w_ifid_adv  = !w_stall && w_ex_free;
    assign w_hlt_issue = w_issue && (w_op == OP_HLT);
    assign in_ready    = !w_stall && !halted && !w_hlt_issue && w_ex_free;
    assign br_taken    = !rst && w_issue && w_is_br && cond_met(r_ifid_instr[11:9], flag);
    assign br_target   = (w_op == OP_BR) ? w_data1 : (w_pc_next + w_boff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_vld   <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
        end else if (w_ifid_adv) begin
            r_ifid_vld <= in_valid && in_ready && !br_taken;
            if (in_valid && in_ready) begin
                r_ifid_instr <= in_instr;
                r_ifid_pc    <= in_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_src1  <= '0;
            ex_src2  <= '0;
            ex_dst   <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
            halted   <= 1'b0;
        end else begin
            if (w_ex_free) begin
                ex_valid <= w_issue;
                if (w_issue) begin
                    ex_ctrl  <= w_ctrl;
                    ex_src1  <= w_src1;
                    ex_src2  <= w_src2;
                    ex_dst   <= w_dst;
                    ex_data1 <= w_data1;
                    ex_data2 <= w_data2;
                    ex_imm   <= w_imm;
                    ex_pc    <= r_ifid_pc;
                end else begin
                    ex_ctrl  <= '0;
                end
            end
            if (w_hlt_issue) halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: two instances (write-through on/off) share all inputs.
module tb_id_pipe_stage;
    import cpu_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, in_valid, ex_ready, wb_we;
    logic [15:0]   in_instr;
    logic [DW-1:0] in_pc, wb_data;
    logic [2:0]    flag;
    logic [3:0]    wb_dst;

    logic          in_ready, br_taken, ex_valid, halted;
    logic [DW-1:0] br_target, ex_data1, ex_data2, ex_imm, ex_pc;
    logic [3:0]    ex_src1, ex_src2, ex_dst;
    ex_ctrl_t      ex_ctrl;

    logic          b_in_ready, b_br_taken, b_ex_valid, b_halted;
    logic [DW-1:0] b_br_target, b_ex_data1, b_ex_data2, b_ex_imm, b_ex_pc;
    logic [3:0]    b_ex_src1, b_ex_src2, b_ex_dst;
    ex_ctrl_t      b_ex_ctrl;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_pipe_stage #(.DATA_W(DW), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flag(flag), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .br_taken(br_taken), .br_target(br_target), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_ctrl(ex_ctrl), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dst(ex_dst),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_pc(ex_pc), .halted(halted)
    );

    id_pipe_stage #(.DATA_W(DW), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flag(flag), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .br_taken(b_br_taken), .br_target(b_br_target), .ex_valid(b_ex_valid), .ex_ready(ex_ready),
        .ex_ctrl(b_ex_ctrl), .ex_src1(b_ex_src1), .ex_src2(b_ex_src2), .ex_dst(b_ex_dst),
        .ex_data1(b_ex_data1), .ex_data2(b_ex_data2), .ex_imm(b_ex_imm), .ex_pc(b_ex_pc),
        .halted(b_halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [15:0] ins, input logic [DW-1:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flag = '0;
        wb_we = 1'b0; wb_dst = '0; wb_data = '0; ex_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; #1;
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_halted",   32'(halted), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_br_taken", 32'(br_taken), 0);
        check("rst_ex_ctrl",  32'(ex_ctrl), 0);
        check("rst_ex_data1", 32'(ex_data1), 0);

        // write R3, then ADD R4,R3,R0; ADD R7,R6,R0 sees a same-cycle write of R6
        @(negedge clk); wb_we = 1'b1; wb_dst = 4'd3; wb_data = 16'h1234;
        @(negedge clk); wb_we = 1'b0; put(16'h0430, 16'h0100);
        @(negedge clk); put(16'h0760, 16'h0102);
        @(negedge clk); in_valid = 1'b0; wb_we = 1'b1; wb_dst = 4'd6; wb_data = 16'h1234; #1;
        check("rf_ex_valid",  32'(ex_valid), 1);
        check("rf_data1",     32'(ex_data1), 'h1234);
        check("rf_data1_nb",  32'(b_ex_data1), 'h1234);
        check("rf_src1",      32'(ex_src1), 3);
        check("rf_dst",       32'(ex_dst), 4);
        check("rf_regwrite",  32'(ex_ctrl.regwrite), 1);
        @(negedge clk); wb_we = 1'b0; #1;
        check("byp_on_data1",  32'(ex_data1), 'h1234);
        check("byp_off_data1", 32'(b_ex_data1), 0);

        // LW R2 then ADD R5,R2,R1: one bubble
        @(negedge clk); put(16'h8210, 16'h0110);
        @(negedge clk); put(16'h0521, 16'h0112); #1;
        check("lu_rdy_before", 32'(in_ready), 1);
        @(negedge clk); put(16'h2811, 16'h0114); #1;
        check("lu_stall_rdy", 32'(in_ready), 0);
        check("lu_ex_is_lw",  32'(ex_ctrl.memtoreg), 1);
        check("lu_ex_dst",    32'(ex_dst), 2);
        @(negedge clk); #1;
        check("lu_bubble",    32'(ex_valid), 0);
        check("lu_rdy_after", 32'(in_ready), 1);
        @(negedge clk); in_valid = 1'b0; #1;
        check("lu_add_valid", 32'(ex_valid), 1);
        check("lu_add_dst",   32'(ex_dst), 5);
        check("lu_add_src2",  32'(ex_src2), 1);
        @(negedge clk); #1;
        check("lu_next_dst",  32'(ex_dst), 8);

        // SUB then B EQ with Z=1: flag stall, taken, wrong-path drop
        @(negedge clk); flag = 3'b100; put(16'h1911, 16'h0120);
        @(negedge clk); put(16'hC205, 16'h0122); #1;
        check("fh_rdy_before", 32'(in_ready), 1);
        @(negedge clk); put(16'h0A11, 16'h0124); #1;
        check("fh_stall_rdy",  32'(in_ready), 0);
        check("fh_no_br_yet",  32'(br_taken), 0);
        @(negedge clk); #1;
        check("fh_br_taken",   32'(br_taken), 1);
        check("fh_br_target",  32'(br_target), 'h012E);
        check("fh_rdy_br",     32'(in_ready), 1);
        check("fh_bubble",     32'(ex_valid), 0);
        @(negedge clk); in_valid = 1'b0; #1;
        check("fh_br_once",    32'(br_taken), 0);
        check("fh_b_issued",   32'(ex_valid), 1);
        check("fh_b_aluop",    32'(ex_ctrl.aluop), 'hC);
        @(negedge clk); #1;
        check("fh_dropped",    32'(ex_valid), 0);

        // unconditional backward B, then B NEQ with Z=1 (not taken)
        @(negedge clk); put(16'hCFFE, 16'h0130);
        @(negedge clk); in_valid = 1'b0; #1;
        check("bu_taken",  32'(br_taken), 1);
        check("bu_target", 32'(br_target), 'h012E);
        @(negedge clk); put(16'hC005, 16'h0132); #1;
        check("bn_idle",   32'(br_taken), 0);
        @(negedge clk); in_valid = 1'b0; #1;
        check("bn_not_taken", 32'(br_taken), 0);

        // EX backpressure for three cycles
        @(negedge clk); put(16'h0B11, 16'h0140);
        @(negedge clk); put(16'h0C11, 16'h0142);
        @(negedge clk); put(16'h0D11, 16'h0144); ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rdy",   32'(in_ready), 0);
            check("bp_valid", 32'(ex_valid), 1);
            check("bp_dst",   32'(ex_dst), 'hB);
            check("bp_pc",    32'(ex_pc), 'h0140);
            @(negedge clk);
        end
        ex_ready = 1'b1; #1;
        check("bp_rdy_resume", 32'(in_ready), 1);
        @(negedge clk); in_valid = 1'b0; #1;
        check("bp_next_dst", 32'(ex_dst), 'hC);
        check("bp_next_pc",  32'(ex_pc), 'h0142);
        @(negedge clk); #1;
        check("bp_last_dst", 32'(ex_dst), 'hD);

        // PCS, LLB, LW immediates and PC-relative data
        @(negedge clk); put(16'hED00, 16'h0160);
        @(negedge clk); put(16'hA1AB, 16'h0162);
        @(negedge clk); put(16'h821F, 16'h0164); #1;
        check("pcs_data1",  32'(ex_data1), 'h0162);
        check("pcs_data2",  32'(ex_data2), 0);
        check("pcs_pcread", 32'(ex_ctrl.pcread), 1);
        @(negedge clk); in_valid = 1'b0; #1;
        check("llb_imm",  32'(ex_imm), 'h00AB);
        check("llb_src1", 32'(ex_src1), 1);
        @(negedge clk); #1;
        check("lw_imm",   32'(ex_imm), 'hFFFF);

        // HLT: sticky halt, then reset clears it
        @(negedge clk); put(16'hF000, 16'h0170);
        @(negedge clk); put(16'h0111, 16'h0172); #1;
        check("hlt_rdy_issue", 32'(in_ready), 0);
        @(negedge clk); #1;
        check("hlt_halted",   32'(halted), 1);
        check("hlt_ex_valid", 32'(ex_valid), 1);
        check("hlt_regwrite", 32'(ex_ctrl.regwrite), 0);
        check("hlt_rdy",      32'(in_ready), 0);
        repeat (3) @(negedge clk);
        #1;
        check("hlt_rdy_later",    32'(in_ready), 0);
        check("hlt_halted_later", 32'(halted), 1);
        check("hlt_drained",      32'(ex_valid), 0);
        @(negedge clk); rst = 1'b1; in_valid = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        check("rst2_halted",   32'(halted), 0);
        check("rst2_in_ready", 32'(in_ready), 1);
        check("rst2_ex_valid", 32'(ex_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
